// File: rtl/fitness_pkg.sv
// Shared defaults, FSM state type and fitness-width helper for the fitness scorer.
package fitness_pkg;

  localparam int WORD_W     = 16;
  localparam int NUM_OUT    = 4;
  localparam int TEST_COUNT = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  // Bits needed to hold the best possible score: every bit of every vector matching.
  function automatic int score_width(input int test_count, input int num_out, input int word_w);
    return $clog2(test_count * num_out * word_w + 1);
  endfunction

endpackage

// File: rtl/fitness_scorer_popcount_match.sv
// Combinational match counter: popcount(mask & ~(actual ^ expected)) across WIDTH bits.
module popcount_match #(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] actual,
  input  logic [WIDTH-1:0] expected,
  input  logic [WIDTH-1:0] mask,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] hits;

  assign hits = mask & ~(actual ^ expected);

  always_comb begin
    // NOTE: give count a value before the loop so no path leaves it unassigned (no latch).
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CNT_W'(hits[i]);
    end
  end

endmodule

// File: rtl/fitness_scorer.sv
// Streaming Hamming-similarity scorer: accumulates matching bits over TEST_COUNT vectors
// and hands out one fitness word per run. Define FITNESS_CARE_MASK_EN to add care_mask.
module fitness_scorer #(
  parameter int WORD_W     = fitness_pkg::WORD_W,
  parameter int NUM_OUT    = fitness_pkg::NUM_OUT,
  parameter int TEST_COUNT = fitness_pkg::TEST_COUNT,
  parameter int SCORE_W    = fitness_pkg::score_width(TEST_COUNT, NUM_OUT, WORD_W)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_OUT*WORD_W-1:0]   actual,
  input  logic [NUM_OUT*WORD_W-1:0]   expected,
`ifdef FITNESS_CARE_MASK_EN
  input  logic [NUM_OUT*WORD_W-1:0]   care_mask,
`endif
  output logic                        score_valid,
  input  logic                        score_ready,
  output logic [SCORE_W-1:0]          score,
  output logic                        busy
);

  import fitness_pkg::*;

  localparam int TOTAL_W = NUM_OUT * WORD_W;
  localparam int MATCH_W = $clog2(TOTAL_W + 1);
  localparam int CNT_W   = $clog2(TEST_COUNT + 1);

  state_t               state;
  state_t               state_next;
  logic [CNT_W-1:0]     accepted;
  logic [CNT_W-1:0]     added;
  logic [SCORE_W-1:0]   acc;
  logic                 s1_valid;
  logic [MATCH_W-1:0]   s1_match;
  logic [MATCH_W-1:0]   match;
  logic [TOTAL_W-1:0]   mask;
  logic                 xfer;

`ifdef FITNESS_CARE_MASK_EN
  assign mask = care_mask;
`else
  assign mask = '1;
`endif

  popcount_match #(
    .WIDTH (TOTAL_W),
    .CNT_W (MATCH_W)
  ) u_popcount (
    .actual   (actual),
    .expected (expected),
    .mask     (mask),
    .count    (match)
  );

  // Ready depends only on registered state, never on in_valid.
  assign in_ready    = (state == ACCUM) && (accepted < CNT_W'(TEST_COUNT));
  assign xfer        = in_valid && in_ready;
  assign score_valid = (state == DONE);
  assign score       = (state == DONE) ? acc : '0;
  assign busy        = (state != IDLE);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = ACCUM;
      // The run ends on the edge that folds in the last stage-1 result.
      ACCUM:   if (s1_valid && (added == CNT_W'(TEST_COUNT - 1))) state_next = DONE;
      DONE:    if (score_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      accepted <= '0;
      added    <= '0;
      acc      <= '0;
      s1_valid <= 1'b0;
      s1_match <= '0;
    end else begin
      state    <= state_next;
      s1_valid <= xfer;
      if (xfer) begin
        s1_match <= match;
      end
      if ((state == IDLE) && start) begin
        accepted <= '0;
        added    <= '0;
        acc      <= '0;
      end else begin
        if (xfer) begin
          accepted <= accepted + CNT_W'(1);
        end
        if (s1_valid) begin
          acc   <= acc + SCORE_W'(s1_match);
          added <= added + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fitness_scorer.sv
// Self-checking bench for fitness_scorer: transaction-level model plus directed runs.
// Exercises the care-mask run when FITNESS_CARE_MASK_EN is defined.
module tb_fitness_scorer;

  localparam int TC = fitness_pkg::TEST_COUNT;
  localparam int SW = fitness_pkg::score_width(fitness_pkg::TEST_COUNT, fitness_pkg::NUM_OUT,
                                               fitness_pkg::WORD_W);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   actual;
  logic [63:0]   expected;
  logic [63:0]   care_mask;
  logic          score_valid;
  logic          score_ready;
  logic [SW-1:0] score;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  localparam logic [63:0] V_EQ = 64'hFFFF_0000_ABCD_1234;
  localparam logic [63:0] V_B  = 64'h5A5A_F00F_0001_8000;

  fitness_scorer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .actual      (actual),
    .expected    (expected),
`ifdef FITNESS_CARE_MASK_EN
    .care_mask   (care_mask),
`endif
    .score_valid (score_valid),
    .score_ready (score_ready),
    .score       (score),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
  endtask

  // ---------------- transaction-level model ----------------
  bit running = 1'b0;
  int m_nacc  = 0;
  int m_sum   = 0;
  int m_last  = 0;

  function automatic int match_of(input logic [63:0] a, input logic [63:0] e, input logic [63:0] m);
    return $countones(~(a ^ e) & m);
  endfunction

  function automatic logic [63:0] eff_mask();
`ifdef FITNESS_CARE_MASK_EN
    return care_mask;
`else
    return '1;
`endif
  endfunction

  function automatic bit m_ready();
    return running && (m_nacc < TC);
  endfunction

  // Score is visible two cycles after the last accepted vector, until consumed.
  function automatic bit m_valid();
    return running && (m_nacc == TC) && (cyc >= m_last + 2);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      running = 1'b0;
      m_nacc  = 0;
      m_sum   = 0;
    end else if (!running) begin
      if (start) begin
        running = 1'b1;
        m_nacc  = 0;
        m_sum   = 0;
      end
    end else begin
      if (m_valid() && score_ready) begin
        running = 1'b0;
      end else if (m_ready() && in_valid) begin
        m_sum  = m_sum + match_of(actual, expected, eff_mask());
        m_nacc = m_nacc + 1;
        m_last = cyc;
      end
    end
  end

  always @(negedge clk) begin
    check("model_in_ready",    64'(in_ready),    64'(m_ready()));
    check("model_score_valid", 64'(score_valid), 64'(m_valid()));
    check("model_score",       64'(score),       m_valid() ? 64'(m_sum) : 64'd0);
    check("model_busy",        64'(busy),        64'(running));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] e, output int xc);
    bit got = 1'b0;
    xc       = 0;
    in_valid = 1'b1;
    actual   = a;
    expected = e;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        xc  = cyc;
        break;
      end
    end
    if (!got) check("xfer_timeout", 64'd0, 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_score(input string name, input int want, input int xc);
    bit got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (score_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check({name, "_valid_timeout"}, 64'd0, 64'd1);
    check({name, "_latency"}, 64'(cyc - xc), 64'd2);
    check({name, "_score"}, 64'(score), 64'(want));
  endtask

  task automatic consume(input string name);
    score_ready = 1'b1;
    tick();
    score_ready = 1'b0;
    @(negedge clk);
    check({name, "_idle_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic run_two(input string name, input logic [63:0] a1, input logic [63:0] e1,
                         input logic [63:0] a2, input logic [63:0] e2, input int want);
    int xc;
    start_run();
    send(a1, e1, xc);
    send(a2, e2, xc);
    wait_score(name, want, xc);
    consume(name);
  endtask

  initial begin
    int xc;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; score_ready = 1'b0;
    actual = '0; expected = '0; care_mask = '1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready",    64'(in_ready),    64'd0);
    check("reset_score_valid", 64'(score_valid), 64'd0);
    check("reset_score",       64'(score),       64'd0);
    check("reset_busy",        64'(busy),        64'd0);

    run_two("all_match", V_EQ, V_EQ, V_B, V_B, 128);
    run_two("all_miss", ~V_EQ, V_EQ, ~V_B, V_B, 0);
    run_two("partial", V_EQ ^ 64'h1, V_EQ, V_B ^ 64'hF000_0000_0000_0000, V_B, 123);

    // Gapped input, held result, late third vector, start ignored while DONE.
    start_run();
    send(V_EQ, V_EQ, xc);
    repeat (3) tick();
    send(V_B, V_B, xc);
    wait_score("gapped", 128, xc);
    in_valid = 1'b1;
    start    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_score", 64'(score), 64'd128);
      check("hold_valid", 64'(score_valid), 64'd1);
      check("hold_no_ready", 64'(in_ready), 64'd0);
    end
    score_ready = 1'b1;
    tick();
    score_ready = 1'b0;
    start       = 1'b0;
    @(negedge clk);
    check("consume_with_start_busy", 64'(busy), 64'd0);
    repeat (2) tick();
    in_valid = 1'b0;

    // Reset mid-run discards the partial score.
    start_run();
    send(V_EQ, V_EQ, xc);
    rst = 1'b1;
    #1;
    check("abort_score_valid", 64'(score_valid), 64'd0);
    check("abort_busy",        64'(busy),        64'd0);
    repeat (2) tick();
    rst = 1'b0;
    run_two("after_abort", V_EQ, V_EQ, V_B, V_B, 128);

`ifdef FITNESS_CARE_MASK_EN
    care_mask = 64'h000F_FFFF_FFFF_FFFF;
    run_two("care_mask", V_EQ, V_EQ, V_B, V_B, 104);
    care_mask = '1;
`endif

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
